// File: rtl/ula_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : ula_arbiter_rr
//  Description : Two-requester round-robin arbiter and sequencer for a shared
//                ALU. It latches operands at grant, waits LAT cycles, captures
//                the result and zero flag, and pulses a one-cycle ack.
//                Optional grant statistics are built with ULA_ARB_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module ula_arbiter_rr #(
    parameter int W   = 3,
    parameter int OPW = 3,
    parameter int RW  = 6,
    parameter int LAT = 1
) (
    input  logic           CLOCK_50,
    input  logic           RESET,
    input  logic           req0,
    input  logic           req1,
    input  logic [W-1:0]   a0,
    input  logic [W-1:0]   a1,
    input  logic [W-1:0]   b0,
    input  logic [W-1:0]   b1,
    input  logic [OPW-1:0] op0,
    input  logic [OPW-1:0] op1,
    output logic           ack0,
    output logic           ack1,
    output logic [RW-1:0]  res,
    output logic           zero,
    output logic           owner,
    output logic           busy,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [RW-1:0]  alu_res,
    input  logic           alu_zero,
    output logic [7:0]     gnt_cnt0,
    output logic [7:0]     gnt_cnt1
);

    localparam int                 c_CNT_W  = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAT_M1 = c_CNT_W'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_last;
    logic                 r_owner;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [W-1:0]         r_alu_a;
    logic [W-1:0]         r_alu_b;
    logic [OPW-1:0]       r_alu_op;
    logic [RW-1:0]        r_res;
    logic                 r_zero;
    logic                 w_grant;
    logic                 w_gnt_idx;
    logic                 w_capture;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and decoded outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_capture   = 1'b0;
        // Under contention the requester not served last wins.
        w_gnt_idx   = (req0 && req1) ? ~r_last : req1;
        ack0        = 1'b0;
        ack1        = 1'b0;
        busy        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                busy        = 1'b1;
                ack0        = ~r_owner;
                ack1        = r_owner;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Grant bookkeeping, operand latch, latency counter and result capture
    // ------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_last   <= 1'b1;
            r_owner  <= 1'b0;
            r_cnt    <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
            r_res    <= '0;
            r_zero   <= 1'b0;
        end else begin
            if (w_grant) begin
                r_last   <= w_gnt_idx;
                r_owner  <= w_gnt_idx;
                r_cnt    <= c_LAT_M1;
                r_alu_a  <= w_gnt_idx ? a1  : a0;
                r_alu_b  <= w_gnt_idx ? b1  : b0;
                r_alu_op <= w_gnt_idx ? op1 : op0;
            end else if (r_state == S_EXEC && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_capture) begin
                r_res  <= alu_res;
                r_zero <= alu_zero;
            end
        end
    end

    assign owner  = r_owner;
    assign alu_a  = r_alu_a;
    assign alu_b  = r_alu_b;
    assign alu_op = r_alu_op;
    assign res    = r_res;
    assign zero   = r_zero;

    // ------------------------------------------------------------------------
    // Grant statistics (saturating at 255, cleared only by reset)
    // ------------------------------------------------------------------------
`ifdef ULA_ARB_STATS_EN
    logic [7:0] r_gnt_cnt0;
    logic [7:0] r_gnt_cnt1;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_gnt_cnt0 <= '0;
            r_gnt_cnt1 <= '0;
        end else if (w_grant) begin
            if (!w_gnt_idx && r_gnt_cnt0 != 8'hFF) begin
                r_gnt_cnt0 <= r_gnt_cnt0 + 8'd1;
            end
            if (w_gnt_idx && r_gnt_cnt1 != 8'hFF) begin
                r_gnt_cnt1 <= r_gnt_cnt1 + 8'd1;
            end
        end
    end

    assign gnt_cnt0 = r_gnt_cnt0;
    assign gnt_cnt1 = r_gnt_cnt1;
`else
    assign gnt_cnt0 = 8'd0;
    assign gnt_cnt1 = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ula_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ula_arbiter_rr
//  Description : Self-checking bench for ula_arbiter_rr; two instances
//                (LAT=1 and LAT=4) share stimulus and are each compared
//                against a transaction-level reference model every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ula_arbiter_rr;

    localparam int W   = 3;
    localparam int OPW = 3;
    localparam int RW  = 6;
`ifdef ULA_ARB_STATS_EN
    localparam bit c_STATS = 1'b1;
`else
    localparam bit c_STATS = 1'b0;
`endif

    logic           CLOCK_50 = 1'b0;
    logic           RESET;
    logic           req0, req1;
    logic [W-1:0]   a0, a1, b0, b1;
    logic [OPW-1:0] op0, op1;

    logic           ack0_1, ack1_1, zero_1, owner_1, busy_1, alu_zero_1;
    logic [RW-1:0]  res_1, alu_res_1;
    logic [W-1:0]   alu_a_1, alu_b_1;
    logic [OPW-1:0] alu_op_1;
    logic [7:0]     gc0_1, gc1_1;

    logic           ack0_4, ack1_4, zero_4, owner_4, busy_4, alu_zero_4;
    logic [RW-1:0]  res_4, alu_res_4;
    logic [W-1:0]   alu_a_4, alu_b_4;
    logic [OPW-1:0] alu_op_4;
    logic [7:0]     gc0_4, gc1_4;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    // Environment ALU: opcode 3'b010 multiplies
    function automatic logic [RW-1:0] alu_fn(logic [W-1:0] a, logic [W-1:0] b, logic [OPW-1:0] op);
        case (op)
            3'd0:    return RW'(a) + RW'(b);
            3'd1:    return RW'(a) - RW'(b);
            3'd2:    return RW'(a) * RW'(b);
            3'd3:    return RW'(a & b);
            3'd4:    return RW'(a | b);
            3'd5:    return RW'(a ^ b);
            3'd6:    return RW'(a);
            default: return RW'(b);
        endcase
    endfunction

    assign alu_res_1  = alu_fn(alu_a_1, alu_b_1, alu_op_1);
    assign alu_zero_1 = (alu_res_1 == '0);
    assign alu_res_4  = alu_fn(alu_a_4, alu_b_4, alu_op_4);
    assign alu_zero_4 = (alu_res_4 == '0);

    ula_arbiter_rr #(.W(W), .OPW(OPW), .RW(RW), .LAT(1)) u_dut1 (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .req0(req0), .req1(req1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .op0(op0), .op1(op1),
        .ack0(ack0_1), .ack1(ack1_1), .res(res_1), .zero(zero_1),
        .owner(owner_1), .busy(busy_1), .alu_a(alu_a_1), .alu_b(alu_b_1),
        .alu_op(alu_op_1), .alu_res(alu_res_1), .alu_zero(alu_zero_1),
        .gnt_cnt0(gc0_1), .gnt_cnt1(gc1_1)
    );

    ula_arbiter_rr #(.W(W), .OPW(OPW), .RW(RW), .LAT(4)) u_dut4 (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .req0(req0), .req1(req1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .op0(op0), .op1(op1),
        .ack0(ack0_4), .ack1(ack1_4), .res(res_4), .zero(zero_4),
        .owner(owner_4), .busy(busy_4), .alu_a(alu_a_4), .alu_b(alu_b_4),
        .alu_op(alu_op_4), .alu_res(alu_res_4), .alu_zero(alu_zero_4),
        .gnt_cnt0(gc0_4), .gnt_cnt1(gc1_4)
    );

    // Transaction model: rem counts the cycles left in the current operation
    // (LAT execute cycles plus the ack cycle); 0 means free to grant.
    typedef struct {
        int             rem;
        bit             owner;
        bit             last;
        logic [W-1:0]   a, b;
        logic [OPW-1:0] op;
        logic [RW-1:0]  pres, res;
        bit             pzero, zero;
        int             c0, c1;
    } mdl_t;

    mdl_t m1, m4;

    function automatic mdl_t mdl_reset();
        mdl_t n;
        n.rem = 0; n.owner = 0; n.last = 1;
        n.a = '0; n.b = '0; n.op = '0;
        n.pres = '0; n.res = '0; n.pzero = 0; n.zero = 0;
        n.c0 = 0; n.c1 = 0;
        return n;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, int lat);
        mdl_t n;
        bit   g;
        n = m;
        if (m.rem > 0) begin
            n.rem = m.rem - 1;
            if (n.rem == 1) begin
                n.res  = m.pres;
                n.zero = m.pzero;
            end
        end else if (req0 || req1) begin
            g       = (req0 && req1) ? !m.last : req1;
            n.owner = g;
            n.last  = g;
            n.a     = g ? a1 : a0;
            n.b     = g ? b1 : b0;
            n.op    = g ? op1 : op0;
            n.pres  = alu_fn(n.a, n.b, n.op);
            n.pzero = (n.pres == '0);
            n.rem   = lat + 1;
            if (c_STATS) begin
                if (!g) n.c0 = (m.c0 < 255) ? m.c0 + 1 : 255;
                else    n.c1 = (m.c1 < 255) ? m.c1 + 1 : 255;
            end
        end
        return n;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cmp_inst(input string p, input mdl_t m,
                            input logic k0, input logic k1, input logic [RW-1:0] r,
                            input logic z, input logic ow, input logic bz,
                            input logic [W-1:0] aa, input logic [W-1:0] ab,
                            input logic [OPW-1:0] ao, input logic [7:0] g0, input logic [7:0] g1);
        check_val({p, "_ack0"},   32'(k0), 32'(m.rem == 1 && !m.owner));
        check_val({p, "_ack1"},   32'(k1), 32'(m.rem == 1 && m.owner));
        check_val({p, "_res"},    32'(r),  32'(m.res));
        check_val({p, "_zero"},   32'(z),  32'(m.zero));
        check_val({p, "_owner"},  32'(ow), 32'(m.owner));
        check_val({p, "_busy"},   32'(bz), 32'(m.rem > 0));
        check_val({p, "_alu_a"},  32'(aa), 32'(m.a));
        check_val({p, "_alu_b"},  32'(ab), 32'(m.b));
        check_val({p, "_alu_op"}, 32'(ao), 32'(m.op));
        check_val({p, "_gcnt0"},  32'(g0), 32'(m.c0));
        check_val({p, "_gcnt1"},  32'(g1), 32'(m.c1));
    endtask

    task automatic cmp_all();
        cmp_inst("l1", m1, ack0_1, ack1_1, res_1, zero_1, owner_1, busy_1,
                 alu_a_1, alu_b_1, alu_op_1, gc0_1, gc1_1);
        cmp_inst("l4", m4, ack0_4, ack1_4, res_4, zero_4, owner_4, busy_4,
                 alu_a_4, alu_b_4, alu_op_4, gc0_4, gc1_4);
    endtask

    // Advance one clock, update the models from the inputs seen at the edge,
    // then compare just after the edge.
    task automatic cycle();
        @(posedge CLOCK_50);
        if (RESET) begin
            m1 = mdl_reset();
            m4 = mdl_reset();
        end else begin
            m1 = mdl_step(m1, 1);
            m4 = mdl_step(m4, 4);
        end
        #1;
        cmp_all();
    endtask

    task automatic rand_operands();
        a0 = W'($urandom); b0 = W'($urandom); op0 = OPW'($urandom);
        a1 = W'($urandom); b1 = W'($urandom); op1 = OPW'($urandom);
    endtask

    task automatic wait_ack(input bit use4, input bit who, input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            cycle();
            if (use4) ok = who ? ack1_4 : ack0_4;
            else      ok = who ? ack1_1 : ack0_1;
        end
        check_val(tag, 32'(ok), 32'd1);
    endtask

    task automatic sync_reset();
        RESET = 1'b1;
        cycle();
        RESET = 1'b0;
    endtask

    int ack_t[4];
    bit ack_o[4];
    int n_ack;

    initial begin
        RESET = 1'b1; req0 = 1'b0; req1 = 1'b0;
        m1 = mdl_reset(); m4 = mdl_reset();

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            req0 = 1'($urandom); req1 = 1'($urandom);
            rand_operands();
            cycle();
        end
        check_val("rst_busy", 32'(busy_1), 32'd0);
        RESET = 1'b0; req0 = 0; req1 = 0;
        cycle();

        // Single request: 5 * 3
        req0 = 1; a0 = 3'd5; b0 = 3'd3; op0 = 3'b010;
        cycle();
        check_val("single_alu_a", 32'(alu_a_1), 32'd5);
        check_val("single_alu_b", 32'(alu_b_1), 32'd3);
        a0 = 3'd1;
        wait_ack(0, 0, "single_ack0_seen");
        check_val("single_res",   32'(res_1),   32'd15);
        check_val("single_zero",  32'(zero_1),  32'd0);
        check_val("single_owner", 32'(owner_1), 32'd0);
        check_val("single_ack1",  32'(ack1_1),  32'd0);
        req0 = 0;
        for (int i = 0; i < 8; i++) cycle();

        // Zero flag via requester 1
        req1 = 1; a1 = 3'd0; b1 = 3'd7; op1 = 3'b010;
        wait_ack(0, 1, "zero_ack1_seen");
        check_val("zero_res",   32'(res_1),   32'd0);
        check_val("zero_flag",  32'(zero_1),  32'd1);
        check_val("zero_owner", 32'(owner_1), 32'd1);
        req1 = 0;
        cycle();
        check_val("zero_ack1_pulse", 32'(ack1_1), 32'd0);
        for (int i = 0; i < 8; i++) cycle();

        // Contention straight after reset: 0,1,0,1 every LAT+2 cycles
        sync_reset();
        req0 = 1; req1 = 1;
        n_ack = 0;
        for (int c = 0; c < 30 && n_ack < 4; c++) begin
            rand_operands();
            cycle();
            if (ack0_1 || ack1_1) begin
                ack_t[n_ack] = c;
                ack_o[n_ack] = ack1_1;
                n_ack++;
            end
        end
        check_val("cont_n_acks", 32'(n_ack), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("cont_order%0d", i), 32'(ack_o[i]), 32'(i % 2));
            if (i > 0) check_val($sformatf("cont_gap%0d", i), 32'(ack_t[i] - ack_t[i-1]), 32'd3);
        end
        req0 = 0; req1 = 0;
        for (int i = 0; i < 8; i++) cycle();

        // Asynchronous reset in the second execute cycle of the LAT=4 instance
        sync_reset();
        req0 = 1; a0 = 3'd6; b0 = 3'd2; op0 = 3'd0;
        cycle();
        cycle();
        check_val("mid_busy_before", 32'(busy_4), 32'd1);
        #5;
        RESET = 1'b1;
        #1;
        m1 = mdl_reset(); m4 = mdl_reset();
        cmp_all();
        check_val("mid_busy_async", 32'(busy_4), 32'd0);
        check_val("mid_alu_a_async", 32'(alu_a_4), 32'd0);
        req0 = 0;
        cycle();
        RESET = 1'b0;
        req1 = 1; a1 = 3'd3; b1 = 3'd3; op1 = 3'd2;
        wait_ack(1, 1, "mid_after_ack1");
        check_val("mid_after_owner", 32'(owner_4), 32'd1);
        check_val("mid_after_res",   32'(res_4),   32'd9);
        req1 = 0;
        for (int i = 0; i < 8; i++) cycle();

        // Grant statistics
        sync_reset();
        req1 = 1;
        for (int i = 0; i < 3; i++) wait_ack(0, 1, "stats_ack1");
        req1 = 0;
        cycle();
        check_val("stats_cnt1", 32'(gc1_1), c_STATS ? 32'd3 : 32'd0);
        check_val("stats_cnt0", 32'(gc0_1), 32'd0);
        req0 = 1;
        for (int i = 0; i < 300; i++) begin
            rand_operands();
            wait_ack(0, 0, "stats_ack0");
        end
        req0 = 0;
        cycle();
        check_val("stats_sat0", 32'(gc0_1), c_STATS ? 32'd255 : 32'd0);
        for (int i = 0; i < 8; i++) cycle();

        // Randomized traffic
        sync_reset();
        for (int c = 0; c < 1500; c++) begin
            if (req0) begin
                if (ack0_1 || $urandom_range(0, 15) == 0) req0 = 1'($urandom);
            end else begin
                req0 = ($urandom_range(0, 2) == 0);
            end
            if (req1) begin
                if (ack1_1 || $urandom_range(0, 15) == 0) req1 = 1'($urandom);
            end else begin
                req1 = ($urandom_range(0, 2) == 0);
            end
            rand_operands();
            RESET = ($urandom_range(0, 199) == 0);
            cycle();
        end
        RESET = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ula_arbiter_rr.md
# ula_arbiter_rr

Round-robin arbiter and sequencer that shares one ALU datapath between two requesters, e.g. the switch/button operator path and a self-test pattern generator. Each requester presents operands A and B plus an opcode with a request. The block grants one requester, latches its operands, drives the ALU, waits a fixed latency and captures result and zero flag. It then returns them to the granted requester with a one-cycle acknowledge. It sits between the operator-input FSMs and the ALU, ahead of the HEX/LEDR display logic.

## Interface
Parameters:
- W, 3, operand width (A, B)
- OPW, 3, opcode width
- RW, 6, result width (2*W)
- LAT, 1, ALU latency in cycles (LAT >= 1)

Ports:
- CLOCK_50  in  1  system clock; one clock, all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- req0, req1  in  1 each  request from requester 0 / 1, held until ack
- a0, a1  in  W each  operand A per requester
- b0, b1  in  W each  operand B per requester
- op0, op1  in  OPW each  opcode per requester
- ack0, ack1  out  1 each  one-cycle acknowledge; res/zero valid in that cycle
- res  out  RW  captured result, held until next capture
- zero  out  1  captured zero flag, held with res
- owner  out  1  requester currently or last served
- busy  out  1  high in EXEC and ACK
- alu_a, alu_b  out  W each  ALU operand drive
- alu_op  out  OPW  ALU opcode drive
- alu_res  in  RW  ALU result
- alu_zero  in  1  ALU zero flag
- gnt_cnt0, gnt_cnt1  out  8 each  grant counters (see Configuration)

## Operation
- States: IDLE, EXEC, ACK.
- IDLE: if any req is high at the rising edge, grant per round-robin. Latch that requester's a/b/op into alu_a/alu_b/alu_op, set owner, load latency counter with LAT-1, go to EXEC.
- Round-robin: pointer `last` holds the last granted index. With both requests high, grant `!last`. With one request high, grant it. `last` updates on every grant.
- EXEC: alu_* held stable. The counter decrements each cycle. On the edge where the counter reads 0, capture alu_res into res and alu_zero into zero, then go to ACK.
- ACK: ack[owner]=1 for exactly this cycle, busy=1. Go to IDLE unconditionally.
- Operands are sampled only at grant. Input changes during EXEC/ACK are ignored.
- A requester that drops req during EXEC is still acked. A requester that keeps req high after ack is a new request at the next IDLE edge.
- Requests arriving during EXEC/ACK wait. No request is lost while held.
- Reset, at any time including mid-EXEC, does all of the following immediately:
  - state=IDLE
  - all outputs 0
  - `last`=1, so requester 0 wins the first contention
  - no ack for the aborted operation

## Timing
- Reset values: ack0=ack1=0, res=0, zero=0, owner=0, busy=0, alu_a=alu_b=alu_op=0, gnt_cnt*=0.
- Request sampled high in IDLE at edge k: alu_* valid and busy=1 from cycle k+1.
- Capture happens at edge k+LAT. Ack is high in cycle k+LAT+1.
- Minimum one IDLE cycle between operations. Throughput is one operation per LAT+2 cycles. With LAT=1 and both requests held, grants alternate 0,1,0,1 every 3 cycles.
- ack0 and ack1 are never high simultaneously.
- res/zero change only at capture edges.

## Configuration
- ULA_ARB_STATS_EN defined:
  - gnt_cnt0/gnt_cnt1 increment on each grant to requester 0/1.
  - They saturate at 255 and clear only on RESET.
- ULA_ARB_STATS_EN undefined:
  - counters are not built; gnt_cnt0/gnt_cnt1 are tied to 0.
  - Arbitration behaviour is identical.

## Test plan
- Reset: assert RESET for 3 cycles with random inputs -> every output 0, busy=0, no ack.
- Single request (LAT=1, ALU model multiplier for op=3'b010): req0 with a0=5, b0=3, op0=3'b010 -> alu_a=5, alu_b=3 in cycle k+1; ack0 pulses in k+2; res=15, zero=0, owner=0; ack1 stays 0.
- Contention: req0 and req1 both raised right after reset and held -> grant order 0,1,0,1. Acks every 3 cycles, never overlapping. Operands latched at grant (change a1 during EXEC of requester 0 -> no effect on that result).
- Zero flag: req1 with a1=0, b1=7, op1=3'b010 -> res=0, zero=1, ack1 single pulse, owner=1.
- Reset mid-operation (LAT=4): assert RESET in the second EXEC cycle -> outputs 0 immediately (asynchronous), no ack. After release, req1 alone is granted normally.
- Stats (with ULA_ARB_STATS_EN): 3 grants to requester 1 -> gnt_cnt1=3, gnt_cnt0=0. 300 grants to requester 0 -> gnt_cnt0=255. Without the macro both counters read 0 throughout.
